hold_detect_mc: RTL and testbench

Multi-channel, parametrised hold detector. Each channel synchronises its input, detects entry into the active level, and emits a one-clock pulse once the level has been held for a runtime-programmable delay. Optionally, the channel then emits periodic repeat pulses while the level stays held. It sits between raw FOC status or trigger lines (PWM phase, fault and button inputs) and the sampling and control logic, replacing per-line single-channel detectors.

---
 rtl/hold_detect_mc_if.sv | 34 +++
 rtl/hold_detect_mc.sv | 141 ++++++++++++++
 tb/tb_hold_detect_mc.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hold_detect_mc_if.sv
// Channel bundle for hold_detect_mc: raw inputs, shared timing controls and pulse/held outputs.
// Abort-count signals exist only when HOLD_DETECT_ABORT_CNT_EN is defined.
interface hold_detect_mc_if #(
  parameter int CH    = 4,
  parameter int CNT_W = 16
);
  logic [CH-1:0]    in;
  logic [CNT_W-1:0] delay;
  logic [CNT_W-1:0] repeat_period;
  logic [CH-1:0]    pulse;
  logic [CH-1:0]    held;
`ifdef HOLD_DETECT_ABORT_CNT_EN
  logic             abort_clr;
  logic [8*CH-1:0]  abort_cnt;

  modport master (
    output in, delay, repeat_period, abort_clr,
    input  pulse, held, abort_cnt
  );
  modport slave (
    input  in, delay, repeat_period, abort_clr,
    output pulse, held, abort_cnt
  );
`else
  modport master (
    output in, delay, repeat_period,
    input  pulse, held
  );
  modport slave (
    input  in, delay, repeat_period,
    output pulse, held
  );
`endif
endinterface

// File: rtl/hold_detect_mc.sv
// Multi-channel hold detector: pulses once a synchronised input has been held active for delay clocks,
// then optionally every repeat_period clocks. HOLD_DETECT_ABORT_CNT_EN adds per-channel abort counters.
module hold_detect_mc #(
  parameter int            CH           = 4,
  parameter int            CNT_W        = 16,
  parameter logic [CH-1:0] ACTIVE_LEVEL = {CH{1'b1}}
) (
  input logic             clk,
  input logic             rstn,
  hold_detect_mc_if.slave bus
);
  typedef enum logic [1:0] {IDLE, COUNT, HELD} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CH-1:0] s1;
  logic [CH-1:0] s2;

  // Resetting to the active level means a line already active at reset release is not an edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1 <= ACTIVE_LEVEL;
      s2 <= ACTIVE_LEVEL;
    end else begin
      s1 <= bus.in;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             a;
    logic             a2;
    logic             pulse_r;
    logic             held_r;
    logic             pulse_d;
    logic             held_d;
    logic             abort_d;

    assign a  = (s1[i] == ACTIVE_LEVEL[i]);
    assign a2 = (s2[i] == ACTIVE_LEVEL[i]);

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        state   <= IDLE;
        cnt     <= '0;
        pulse_r <= 1'b0;
        held_r  <= 1'b0;
      end else begin
        state   <= state_d;
        cnt     <= cnt_d;
        pulse_r <= pulse_d;
        held_r  <= held_d;
      end
    end

    // In HELD a non-zero count only exists if the period was non-zero at load, so reaching 1
    // always fires; reloading with a period that has since dropped to 0 ends the repeats.
    always_comb begin
      state_d = state;
      cnt_d   = cnt;
      unique case (state)
        IDLE: begin
          if (a && !a2 && (bus.delay != '0)) begin
            state_d = COUNT;
            cnt_d   = bus.delay;
          end
        end
        COUNT: begin
          if (!a) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt == ONE) begin
            state_d = HELD;
            cnt_d   = bus.repeat_period;
          end else begin
            cnt_d = cnt - ONE;
          end
        end
        HELD: begin
          if (!a) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt == ONE) begin
            cnt_d = bus.repeat_period;
          end else if (cnt != '0) begin
            cnt_d = cnt - ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    always_comb begin
      pulse_d = 1'b0;
      abort_d = 1'b0;
      unique case (state)
        COUNT: begin
          if (!a) abort_d = 1'b1;
          else if (cnt == ONE) pulse_d = 1'b1;
        end
        HELD: begin
          if (a && (cnt == ONE)) pulse_d = 1'b1;
        end
        default: begin
          pulse_d = 1'b0;
        end
      endcase
      held_d = (state_d == HELD);
    end

    assign bus.pulse[i] = pulse_r;
    assign bus.held[i]  = held_r;

`ifdef HOLD_DETECT_ABORT_CNT_EN
    logic [7:0] abort_q;

    // A clear wins over an abort landing on the same edge.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        abort_q <= 8'd0;
      end else if (bus.abort_clr) begin
        abort_q <= 8'd0;
      end else if (abort_d && (abort_q != 8'hFF)) begin
        abort_q <= abort_q + 8'd1;
      end
    end

    assign bus.abort_cnt[8*i +: 8] = abort_q;
`else
    logic unused_abort;
    assign unused_abort = abort_d;
`endif
  end
endmodule

// File: tb/tb_hold_detect_mc.sv
// Directed bench for hold_detect_mc: a table of single-channel hold scenarios plus hand-written
// sequences for reset, bounce, zero delay, simultaneous channels and mid-count reset.
module tb_hold_detect_mc;
  localparam logic [3:0] ACT     = 4'b0111;
  localparam logic [3:0] IDLE_IN = 4'b1000;

  logic clk;
  logic rstn;
  int   total;
  int   bad;

  hold_detect_mc_if #(.CH(4), .CNT_W(16)) bus ();

  hold_detect_mc #(
    .CH(4),
    .CNT_W(16),
    .ACTIVE_LEVEL(ACT)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int d;
    int r;
    int h;
    int first;
    int last;
    int npulse;
    int nheld;
  } vec_t;

  vec_t vecs [8];

  task automatic check_output(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edge k=0 is E0: the input is driven at the preceding negedge; released before edge h.
  task automatic apply_stimulus(input vec_t v, input int idx);
    int         first;
    int         last;
    int         npulse;
    int         nheld;
    int         nother;
    int         held_after;
    logic [3:0] act_in;
    logic [3:0] other;
    first      = 0;
    last       = 0;
    npulse     = 0;
    nheld      = 0;
    nother     = 0;
    held_after = 0;
    act_in     = IDLE_IN;
    act_in[v.ch] = ACT[v.ch];
    other      = ~(4'b0001 << v.ch);
    bus.delay         = 16'(v.d);
    bus.repeat_period = 16'(v.r);
    @(negedge clk);
    bus.in = act_in;
    for (int k = 0; k <= v.h + 4; k++) begin
      tick();
      if (bus.pulse[v.ch]) begin
        if (first == 0) first = k;
        last = k;
        npulse++;
      end
      if (bus.held[v.ch]) nheld++;
      if (k == v.h + 1) held_after = int'(bus.held[v.ch]);
      if (((bus.pulse | bus.held) & other) != 4'b0000) nother++;
      if (k == v.h - 1) begin
        @(negedge clk);
        bus.in = IDLE_IN;
      end
    end
    check_output($sformatf("v%0d_first", idx), first, v.first);
    check_output($sformatf("v%0d_last", idx), last, v.last);
    check_output($sformatf("v%0d_npulse", idx), npulse, v.npulse);
    check_output($sformatf("v%0d_nheld", idx), nheld, v.nheld);
    check_output($sformatf("v%0d_held_after", idx), held_after, 0);
    check_output($sformatf("v%0d_other", idx), nother, 0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int first;
    int npulse;
    int noise;
    total = 0;
    bad   = 0;

    // ch, D, R, hold, first, last, pulses, held cycles
    vecs[0] = '{0, 100, 0, 300, 101, 101, 1, 200};
    vecs[1] = '{2, 10, 25, 100, 11, 86, 4, 90};
    vecs[2] = '{1, 100, 0, 60, 0, 0, 0, 0};
    vecs[3] = '{1, 1, 0, 5, 2, 2, 1, 4};
    vecs[4] = '{3, 3, 2, 10, 4, 10, 4, 7};
    vecs[5] = '{0, 5, 1, 8, 6, 8, 3, 3};
    vecs[6] = '{1, 7, 0, 7, 0, 0, 0, 0};
    vecs[7] = '{1, 7, 0, 8, 8, 8, 1, 1};

    // ch3 (active-low) is already active while reset is held.
    rstn              = 1'b0;
    bus.in            = 4'b0000;
    bus.delay         = 16'd5;
    bus.repeat_period = 16'd0;
`ifdef HOLD_DETECT_ABORT_CNT_EN
    bus.abort_clr     = 1'b0;
`endif
    repeat (3) tick();
    check_output("reset_pulse", int'(bus.pulse), 0);
    check_output("reset_held", int'(bus.held), 0);
`ifdef HOLD_DETECT_ABORT_CNT_EN
    check_output("reset_abort", int'(bus.abort_cnt), 0);
`endif
    @(negedge clk);
    rstn = 1'b1;
    noise = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if ((bus.pulse | bus.held) != 4'b0000) noise++;
    end
    check_output("active_at_reset_quiet", noise, 0);

    @(negedge clk);
    bus.in = IDLE_IN;
    repeat (4) @(negedge clk);
    bus.in = 4'b0000;
    first  = 0;
    npulse = 0;
    for (int k = 0; k <= 10; k++) begin
      tick();
      if (bus.pulse[3]) begin
        if (first == 0) first = k;
        npulse++;
      end
    end
    check_output("reassert_first", first, 6);
    check_output("reassert_npulse", npulse, 1);
    @(negedge clk);
    bus.in = IDLE_IN;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 8; i++) apply_stimulus(vecs[i], i);

`ifdef HOLD_DETECT_ABORT_CNT_EN
    check_output("abort_ch1_table", int'(bus.abort_cnt[15:8]), 2);
    @(negedge clk);
    bus.abort_clr = 1'b1;
    @(negedge clk);
    bus.abort_clr = 1'b0;
    check_output("abort_clr", int'(bus.abort_cnt[15:8]), 0);
`endif

    // Bounce on ch1: 60 active, 5 inactive, then active again; the delay restarts in full.
    bus.delay         = 16'd100;
    bus.repeat_period = 16'd0;
    @(negedge clk);
    bus.in = IDLE_IN | 4'b0010;
    repeat (60) @(negedge clk);
    bus.in = IDLE_IN;
    repeat (5) @(negedge clk);
    bus.in = IDLE_IN | 4'b0010;
    first  = 0;
    npulse = 0;
    for (int k = 0; k <= 110; k++) begin
      tick();
      if (bus.pulse[1]) begin
        if (first == 0) first = k;
        npulse++;
      end
    end
    check_output("bounce_first", first, 101);
    check_output("bounce_npulse", npulse, 1);
    check_output("bounce_held", int'(bus.held[1]), 1);
`ifdef HOLD_DETECT_ABORT_CNT_EN
    check_output("bounce_abort", int'(bus.abort_cnt[15:8]), 1);
    check_output("bounce_abort_ch0", int'(bus.abort_cnt[7:0]), 0);
`endif
    @(negedge clk);
    bus.in = IDLE_IN;
    repeat (4) @(negedge clk);

    // Zero delay: toggling inputs must never start a count.
    bus.delay = 16'd0;
    noise = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      bus.in = 4'($urandom);
      tick();
      if ((bus.pulse | bus.held) != 4'b0000) noise++;
    end
    check_output("zero_delay_quiet", noise, 0);
    @(negedge clk);
    bus.in = IDLE_IN;
    repeat (4) @(negedge clk);

    // ch0 and ch3 asserted on the same edge with D=3.
    bus.delay = 16'd3;
    bus.in    = 4'b0001;
    noise = 0;
    for (int k = 0; k <= 6; k++) begin
      tick();
      if (k == 4) check_output("simul_pulse", int'(bus.pulse), 9);
      else if (bus.pulse != 4'b0000) noise++;
    end
    check_output("simul_quiet", noise, 0);
    @(negedge clk);
    bus.in = IDLE_IN;
    repeat (4) @(negedge clk);

    // ch2 parked in HELD, ch0 counting; reset lands when ch0 has cnt=2.
    bus.delay = 16'd10;
    bus.in    = IDLE_IN | 4'b0100;
    repeat (15) tick();
    @(negedge clk);
    bus.in = IDLE_IN | 4'b0101;
    for (int k = 0; k <= 9; k++) tick();
    check_output("pre_reset_held2", int'(bus.held[2]), 1);
    #2;
    rstn = 1'b0;
    #1;
    check_output("midreset_pulse", int'(bus.pulse), 0);
    check_output("midreset_held", int'(bus.held), 0);
    @(negedge clk);
    rstn = 1'b1;
    noise = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if ((bus.pulse | bus.held) != 4'b0000) noise++;
    end
    check_output("post_reset_quiet", noise, 0);
    @(negedge clk);
    bus.in = IDLE_IN;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
